mux_rr_n_1: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
- Successor to the gate-level 2:1 and 4:1 muxes, generalised in channel count and data width.
- Adds a fixed-select mode and a round-robin arbitration mode.
- Sits between several producer streams and one consumer; one output register stage.

---
 rtl/mux_rr_n_1_pkg.sv | 20 ++
 rtl/mux_rr_n_1_rr_arbiter.sv | 95 +++++++++
 rtl/mux_rr_n_1.sv | 101 ++++++++++
 tb/tb_mux_rr_n_1.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_n_1_pkg.sv
// Shared types and helpers for the N-channel registered round-robin multiplexer.
// The optional packet-lock build is selected with MUX_RR_PACKET_LOCK_EN.
package mux_rr_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;

  // Upper bound on channel count accepted by the one-hot decode helper.
  localparam int MAX_CH = 64;

  // Converts a one-hot (or all-zero) vector to its bit index.
  function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = idx | (oh[i] ? 32'(i) : 32'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_n_1_rr_arbiter.sv
// Round-robin arbiter that owns the priority pointer and, with
// MUX_RR_PACKET_LOCK_EN defined, the packet lock state.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
`ifdef MUX_RR_PACKET_LOCK_EN
  input  logic             last,
`endif
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0]  ptr_r;
  logic [N_CH-1:0]   rr_grant_s;
  logic [N_CH-1:0]   grant_s;
  logic [MAX_CH-1:0] grant_pad_s;
  logic              found_s;
  int                idx_v;

`ifdef MUX_RR_PACKET_LOCK_EN
  logic              locked_r;
  logic [SEL_W-1:0]  lock_ch_r;
`endif

  // Search upward from ptr+1, wrapping modulo N_CH, for the first requester.
  always_comb begin
    rr_grant_s = '0;
    found_s    = 1'b0;
    idx_v      = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx_v = int'(ptr_r) + k;
      if (idx_v >= N_CH) begin
        idx_v = idx_v - N_CH;
      end else begin
        idx_v = idx_v;
      end
      rr_grant_s[SEL_W'(idx_v)] = !found_s && req[SEL_W'(idx_v)];
      found_s = found_s | req[SEL_W'(idx_v)];
    end
  end

  // A held lock pins the grant to its channel regardless of other requests.
  always_comb begin
    grant_s = '0;
`ifdef MUX_RR_PACKET_LOCK_EN
    if (locked_r) begin
      grant_s[lock_ch_r] = req[lock_ch_r];
    end else begin
      grant_s = rr_grant_s;
    end
`else
    grant_s = rr_grant_s;
`endif
    grant_pad_s = '0;
    grant_pad_s[N_CH-1:0] = grant_s;
  end

  assign grant     = grant_s;
  assign grant_idx = SEL_W'(onehot_to_idx(grant_pad_s));

  // Pointer moves to the winner only when a beat actually transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= SEL_W'(N_CH - 1);
    end else if (advance) begin
      ptr_r <= grant_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`ifdef MUX_RR_PACKET_LOCK_EN
  // Lock opens on a non-final beat and releases on the final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_r  <= 1'b0;
      lock_ch_r <= '0;
    end else if (advance) begin
      locked_r  <= !last;
      lock_ch_r <= grant_idx;
    end else begin
      locked_r  <= locked_r;
      lock_ch_r <= lock_ch_r;
    end
  end
`endif

endmodule

// File: rtl/mux_rr_n_1.sv
// N-channel registered multiplexer with fixed-select and round-robin modes.
// Define MUX_RR_PACKET_LOCK_EN to add in_last and packet-granular RR locking.
module mux_rr_n_1
  import mux_rr_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
`ifdef MUX_RR_PACKET_LOCK_EN
  input  logic [N_CH-1:0]       in_last,
`endif
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch
);

  logic [N_CH-1:0]  fixed_grant_s;
  logic [N_CH-1:0]  arb_grant_s;
  logic [N_CH-1:0]  grant_s;
  logic [SEL_W-1:0] arb_idx_s;
  logic [SEL_W-1:0] idx_s;
  logic [WIDTH-1:0] data_sel_s;
  logic             rr_mode_s;
  logic             load_s;
  logic             xfer_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_ch_r;

  assign rr_mode_s = (mux_mode_e'(mode) == MODE_RR);
  assign load_s    = !out_valid_r | out_ready;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (xfer_s & rr_mode_s),
`ifdef MUX_RR_PACKET_LOCK_EN
    .last      (|(in_last & grant_s)),
`endif
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // Fixed grant, mode selection and data steering; out-of-range sel matches nothing.
  always_comb begin
    fixed_grant_s = '0;
    data_sel_s    = '0;
    for (int i = 0; i < N_CH; i++) begin
      fixed_grant_s[i] = in_valid[i] && (sel == SEL_W'(i));
    end
    if (rr_mode_s) begin
      grant_s = arb_grant_s;
      idx_s   = arb_idx_s;
    end else begin
      grant_s = fixed_grant_s;
      idx_s   = sel;
    end
    for (int i = 0; i < N_CH; i++) begin
      data_sel_s = data_sel_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  assign in_ready = load_s ? grant_s : '0;
  assign xfer_s   = load_s & (|grant_s);

  // Output stage: capture on transfer, drain on an empty load, hold under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_sel_s;
      out_ch_r    <= idx_s;
    end else if (load_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_rr_n_1.sv
// Directed self-checking bench for mux_rr_n_1 (N_CH=4, WIDTH=8).
// The packet-lock scenario runs only when MUX_RR_PACKET_LOCK_EN is defined.
module tb_mux_rr_n_1;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
`ifdef MUX_RR_PACKET_LOCK_EN
  logic [3:0]  in_last;
`endif
  logic        mode;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;

  int n_checks;
  int n_fail;

  mux_rr_n_1 #(.N_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MUX_RR_PACKET_LOCK_EN
    .in_last   (in_last),
`endif
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 4'b0000; in_data = 32'h0; mode = 1'b1; sel = 2'd0; out_ready = 1'b0;
`ifdef MUX_RR_PACKET_LOCK_EN
    in_last = 4'b1111;
`endif
    rst = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
    n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %0d exp 0", out_ch); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; in_data = 32'h0000_005A; out_ready = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin n_fail++; $display("FAIL mid_capture got v=%b d=%h exp v=1 d=5a", out_valid, out_data); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_async got v=%b d=%h c=%0d exp 0/00/0", out_valid, out_data, out_ch); end
    step();
    rst = 1'b1; in_valid = 4'b1111; in_data = 32'hA3A2_A1A0; out_ready = 1'b1;
    step();
    n_checks++; if (out_data !== 8'hA0 || out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_first got d=%h c=%0d exp a0/0", out_data, out_ch); end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'hA3A2_A1A0; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_ready0 got %b exp 0001", in_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== (8'hA0 + 8'(k % 4)) || out_ch !== 2'(k % 4)) begin
        n_fail++; $display("FAIL rr_seq%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d", k, out_valid, out_data, out_ch, 8'hA0 + 8'(k % 4), k % 4);
      end
    end
  endtask

  task automatic test_rr_skip_wrap();
    logic [1:0] exp_ch [3];
    exp_ch[0] = 2'd3; exp_ch[1] = 2'd0; exp_ch[2] = 2'd3;
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; in_data = 32'h1312_1110; out_ready = 1'b1;
    step();
    n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL skip_prime got %0d exp 0", out_ch); end
    in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (out_ch !== exp_ch[k] || out_data !== (8'h10 + 8'(exp_ch[k]))) begin
        n_fail++; $display("FAIL skip%0d got c=%0d d=%h exp c=%0d d=%h", k, out_ch, out_data, exp_ch[k], 8'h10 + 8'(exp_ch[k]));
      end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h4433_2211; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h33 || out_ch !== 2'd2) begin
        n_fail++; $display("FAIL fixed%0d got v=%b d=%h c=%0d exp 1/33/2", k, out_valid, out_data, out_ch);
      end
    end
    in_valid = 4'b1011;
    #1;
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL fixed_noready got %b exp 0000", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h33 || out_ch !== 2'd2) begin n_fail++; $display("FAIL fixed_drain got v=%b d=%h c=%0d exp 0/33/2", out_valid, out_data, out_ch); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; in_data = 32'h0000_0011; out_ready = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("FAIL bp_capture got v=%b d=%h exp 1/11", out_valid, out_data); end
    in_data = 32'h0000_0022;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000 || out_data !== 8'h11 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d got r=%b d=%h v=%b exp 0000/11/1", k, in_ready, out_data, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release got %b exp 0001", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin n_fail++; $display("FAIL bp_next got v=%b d=%h exp 1/22", out_valid, out_data); end
  endtask

`ifdef MUX_RR_PACKET_LOCK_EN
  task automatic test_packet_lock();
    logic [1:0] exp_ch [4];
    logic [7:0] exp_d  [4];
    exp_ch[0] = 2'd1; exp_ch[1] = 2'd1; exp_ch[2] = 2'd1; exp_ch[3] = 2'd2;
    exp_d[0] = 8'hB0; exp_d[1] = 8'hB1; exp_d[2] = 8'hB2; exp_d[3] = 8'hC2;
    do_reset();
    mode = 1'b1; in_last = 4'b1111; in_valid = 4'b0001; in_data = 32'h0000_0000; out_ready = 1'b1;
    step();
    in_valid = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      in_data = {8'h00, 8'hC2, 8'hB0 + 8'(k), 8'hC0};
      in_last = (k == 2) ? 4'b1111 : 4'b1101;
      step();
      n_checks++;
      if (out_ch !== exp_ch[k] || out_data !== exp_d[k]) begin
        n_fail++; $display("FAIL lock%0d got c=%0d d=%h exp c=%0d d=%h", k, out_ch, out_data, exp_ch[k], exp_d[k]);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reset_midstream();
    test_rr_fairness();
    test_rr_skip_wrap();
    test_fixed();
    test_backpressure();
`ifdef MUX_RR_PACKET_LOCK_EN
    test_packet_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
